// File: rtl/yarp_dmem_responder.sv
// Data-memory responder for the YARP load/store port.
// Accepts one request at a time. After LATENCY wait cycles it returns
// right-aligned, zero-filled load data or a store acknowledge. The backing
// store is a word-wide SRAM with per-byte write lanes.
module yarp_dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic [1:0]  data_byte_i,
    input  logic        data_wr_i,
    input  logic [31:0] data_wr_data_i,
    output logic        data_gnt_o,
    output logic        data_rsp_valid_o,
    output logic [31:0] data_rd_data_o,
    output logic        data_err_o
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // One past the last valid byte address; 33 bits so the bound cannot wrap.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  LAT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Reserved size, misalignment, or an address outside the array.
    function automatic logic access_fault(input logic [31:0] addr, input logic [1:0] sz);
        logic f;
        case (sz)
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = addr[0];
            SZ_WORD: f = (addr[1:0] != 2'b00);
            default: f = 1'b1;
        endcase
        f = f | ({1'b0, addr} < {1'b0, BASE_ADDR}) | ({1'b0, addr} >= END_ADDR);
        return f;
    endfunction

    // Byte-lane write enables for a store of the given size at the given lane.
    function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] lane);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = 4'b0011 << lane;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Shift the addressed bytes down to bit 0 and zero everything above the access size.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] lane);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (sz)
            SZ_BYTE: res = {24'd0, sh[7:0]};
            SZ_HALF: res = {16'd0, sh[15:0]};
            SZ_WORD: res = sh;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    logic [31:0] r_mem [DEPTH_WORDS];

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_wr;
    logic [31:0] r_wr_data;
    logic        r_fault;
    logic        r_rsp_valid;
    logic [31:0] r_rd_data;
    logic        r_err;

    logic        w_accept;
    logic        w_enter_resp;
    logic [31:0] w_op_addr;
    logic [1:0]  w_op_size;
    logic        w_op_wr;
    logic [31:0] w_op_wr_data;
    logic        w_op_fault;
    logic [1:0]  w_lane;
    logic [AW-1:0] w_idx;
    logic [3:0]  w_be;
    logic [31:0] w_wr_shifted;
    logic        w_mem_we;

    assign data_gnt_o       = reset_n & (r_state == ST_IDLE);
    assign data_rsp_valid_o = r_rsp_valid;
    assign data_rd_data_o   = r_rd_data;
    assign data_err_o       = r_err;

    assign w_accept = data_req_i & data_gnt_o;

    // With zero latency the array is touched on the acceptance edge itself, so the
    // operand comes straight from the port while idle and from the latch otherwise.
    assign w_op_addr    = (r_state == ST_IDLE) ? data_addr_i    : r_addr;
    assign w_op_size    = (r_state == ST_IDLE) ? data_byte_i    : r_size;
    assign w_op_wr      = (r_state == ST_IDLE) ? data_wr_i      : r_wr;
    assign w_op_wr_data = (r_state == ST_IDLE) ? data_wr_data_i : r_wr_data;
    assign w_op_fault   = (r_state == ST_IDLE) ? access_fault(data_addr_i, data_byte_i) : r_fault;

    assign w_lane       = w_op_addr[1:0];
    assign w_idx        = AW'((w_op_addr - BASE_ADDR) >> 2);
    assign w_be         = lane_enables(w_op_size, w_lane);
    assign w_wr_shifted = w_op_wr_data << {w_lane, 3'b000};
    assign w_enter_resp = (w_next == ST_RESP);
    assign w_mem_we     = w_enter_resp & w_op_wr & ~w_op_fault;

    // Next-state and wait counter decode.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next     = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                    w_cnt_next = 4'd0;
                end else begin
                    w_next     = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == LAT_LAST) begin
                    w_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the request and its fault decision on the acceptance edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= 32'd0;
            r_size    <= 2'b00;
            r_wr      <= 1'b0;
            r_wr_data <= 32'd0;
            r_fault   <= 1'b0;
        end else if (w_accept) begin
            r_addr    <= data_addr_i;
            r_size    <= data_byte_i;
            r_wr      <= data_wr_i;
            r_wr_data <= data_wr_data_i;
            r_fault   <= access_fault(data_addr_i, data_byte_i);
        end
    end

    // Response registers: loaded on the edge entering RESP, cleared on the next edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rd_data   <= 32'd0;
            r_err       <= 1'b0;
        end else if (w_enter_resp) begin
            r_rsp_valid <= 1'b1;
            r_err       <= w_op_fault;
            r_rd_data   <= (w_op_fault | w_op_wr) ? 32'd0
                                                  : load_extract(r_mem[w_idx], w_op_size, w_lane);
        end else begin
            r_rsp_valid <= 1'b0;
            r_rd_data   <= 32'd0;
            r_err       <= 1'b0;
        end
    end

    // Byte-lane SRAM write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wr_shifted[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_yarp_dmem_responder.sv
// Scoreboard bench for yarp_dmem_responder: three instances (LATENCY 1, 0, 3).
module tb_yarp_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n  [3];
    logic        req    [3];
    logic [31:0] addr   [3];
    logic [1:0]  sz     [3];
    logic        wr     [3];
    logic [31:0] wdata  [3];
    logic        gnt    [3];
    logic        rsp_v  [3];
    logic [31:0] rd     [3];
    logic        err    [3];

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        int          inst;
        logic [31:0] rd;
        logic        err;
        string       tag;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        yarp_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT), .BASE_ADDR(32'h0000_2000)) u_dut (
            .clk              (clk),
            .reset_n          (rst_n[g]),
            .data_req_i       (req[g]),
            .data_addr_i      (addr[g]),
            .data_byte_i      (sz[g]),
            .data_wr_i        (wr[g]),
            .data_wr_data_i   (wdata[g]),
            .data_gnt_o       (gnt[g]),
            .data_rsp_valid_o (rsp_v[g]),
            .data_rd_data_o   (rd[g]),
            .data_err_o       (err[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every response must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 3; g++) begin
            if (rsp_v[g] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("unexpected_rsp_inst%0d", g), 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.tag, "_inst"}, 32'(g), 32'(e.inst));
                    chk({e.tag, "_rd"}, rd[g], e.rd);
                    chk({e.tag, "_err"}, {31'd0, err[g]}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic drive(input int g, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        req[g] = 1'b1; wr[g] = w; sz[g] = s; addr[g] = a; wdata[g] = d;
    endtask

    task automatic do_txn(input int g, input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                          input string tag);
        int cyc;
        exp_t e;
        @(negedge clk);
        chk({tag, "_gnt"}, {31'd0, gnt[g]}, 32'd1);
        e.inst = g; e.rd = exp_rd; e.err = exp_err; e.tag = tag;
        sb_q.push_back(e);
        drive(g, w, s, a, d);
        @(posedge clk);
        @(negedge clk);
        req[g] = 1'b0;
        cyc = 1;
        chk({tag, "_gnt_busy"}, {31'd0, gnt[g]}, 32'd0);
        while (rsp_v[g] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(lat_of(g) + 1));
        @(negedge clk);
        chk({tag, "_after_v_e_g"}, {29'd0, rsp_v[g], err[g], gnt[g]}, 32'd1);
        chk({tag, "_after_rd"}, rd[g], 32'd0);
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst_n[g] = 1'b0; req[g] = 1'b0; addr[g] = 32'd0;
            sz[g] = 2'b00; wr[g] = 1'b0; wdata[g] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_gnt%0d", g), {31'd0, gnt[g]}, 32'd0);
            chk($sformatf("rst_out%0d", g), {rd[g][29:0], rsp_v[g], err[g]}, 32'd0);
        end
        for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rel_gnt%0d", g), {31'd0, gnt[g]}, 32'd1);
            chk($sformatf("rel_rsp%0d", g), {31'd0, rsp_v[g]}, 32'd0);
        end

        // LATENCY=1 functional checks
        do_txn(0, 1'b1, 2'b11, 32'h2000, 32'hDEADBEEF, 32'h0, 1'b0, "sw_2000");
        do_txn(0, 1'b0, 2'b11, 32'h2000, 32'h0, 32'hDEADBEEF, 1'b0, "lw_2000");
        do_txn(0, 1'b1, 2'b00, 32'h2002, 32'h0000005A, 32'h0, 1'b0, "sb_2002");
        do_txn(0, 1'b0, 2'b11, 32'h2000, 32'h0, 32'hDE5ABEEF, 1'b0, "lw_merged");
        do_txn(0, 1'b0, 2'b01, 32'h2002, 32'h0, 32'h0000DE5A, 1'b0, "lh_2002");
        do_txn(0, 1'b0, 2'b00, 32'h2003, 32'h0, 32'h000000DE, 1'b0, "lb_2003");
        do_txn(0, 1'b0, 2'b11, 32'h2002, 32'h0, 32'h0, 1'b1, "lw_misal");
        do_txn(0, 1'b0, 2'b01, 32'h2001, 32'h0, 32'h0, 1'b1, "lh_misal");
        do_txn(0, 1'b0, 2'b10, 32'h2000, 32'h0, 32'h0, 1'b1, "rsvd_size");
        do_txn(0, 1'b1, 2'b11, 32'h2002, 32'h1, 32'h0, 1'b1, "sw_misal");
        do_txn(0, 1'b0, 2'b11, 32'h2000, 32'h0, 32'hDE5ABEEF, 1'b0, "lw_unchanged");
        do_txn(0, 1'b0, 2'b11, 32'h1FFC, 32'h0, 32'h0, 1'b1, "lw_below");
        do_txn(0, 1'b0, 2'b11, 32'h3000, 32'h0, 32'h0, 1'b1, "lw_end");
        do_txn(0, 1'b1, 2'b11, 32'h2FFC, 32'h12345678, 32'h0, 1'b0, "sw_last");
        do_txn(0, 1'b1, 2'b01, 32'h2FFE, 32'h0000BEEF, 32'h0, 1'b0, "sh_last");
        do_txn(0, 1'b0, 2'b11, 32'h2FFC, 32'h0, 32'hBEEF5678, 1'b0, "lw_last");
        do_txn(0, 1'b0, 2'b00, 32'h2FFD, 32'h0, 32'h00000056, 1'b0, "lb_last");

        // LATENCY=0
        do_txn(1, 1'b1, 2'b11, 32'h2010, 32'hCAFEF00D, 32'h0, 1'b0, "l0_sw");
        do_txn(1, 1'b0, 2'b11, 32'h2010, 32'h0, 32'hCAFEF00D, 1'b0, "l0_lw");
        do_txn(1, 1'b0, 2'b01, 32'h2012, 32'h0, 32'h0000CAFE, 1'b0, "l0_lh");

        // LATENCY=3, then reset during the WAIT of a store
        do_txn(2, 1'b1, 2'b11, 32'h2020, 32'h11223344, 32'h0, 1'b0, "l3_sw");
        do_txn(2, 1'b0, 2'b11, 32'h2020, 32'h0, 32'h11223344, 1'b0, "l3_lw");
        @(negedge clk);
        drive(2, 1'b1, 2'b11, 32'h2020, 32'h55667788);
        @(posedge clk);
        @(negedge clk);
        req[2] = 1'b0;
        rst_n[2] = 1'b0;
        #1;
        chk("midrst_gnt", {31'd0, gnt[2]}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n[2] = 1'b1;
        #1;
        chk("midrst_rel_gnt", {31'd0, gnt[2]}, 32'd1);
        repeat (6) @(negedge clk);
        do_txn(2, 1'b0, 2'b11, 32'h2020, 32'h0, 32'h11223344, 1'b0, "midrst_lw");

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
